// File: rtl/seg7_pkg.sv
// Shared glyph constants, FSM state type and combinational glyph decoder
// for the 7-segment link (bit0=a .. bit6=g, active high).
package seg7_pkg;

  localparam logic [6:0] GLYPH_0     = 7'h3F;
  localparam logic [6:0] GLYPH_1     = 7'h06;
  localparam logic [6:0] GLYPH_2     = 7'h5B;
  localparam logic [6:0] GLYPH_3     = 7'h4F;
  localparam logic [6:0] GLYPH_4     = 7'h66;
  localparam logic [6:0] GLYPH_5     = 7'h6D;
  localparam logic [6:0] GLYPH_6     = 7'h7D;
  localparam logic [6:0] GLYPH_7     = 7'h07;
  localparam logic [6:0] GLYPH_8     = 7'h7F;
  localparam logic [6:0] GLYPH_9     = 7'h6F;
  localparam logic [6:0] GLYPH_BLANK = 7'h00;

  typedef enum logic {
    IDLE,
    SETTLE
  } state_e;

  typedef struct packed {
    logic       err;
    logic       blank;
    logic [3:0] digit;
  } seg7_dec_t;

  // Illegal patterns report digit 4'hF so a consumer ignoring err still sees garbage clearly.
  function automatic seg7_dec_t seg7_decode(input logic [6:0] seg);
    seg7_dec_t r;
    r.err   = 1'b0;
    r.blank = 1'b0;
    r.digit = 4'd0;
    case (seg)
      GLYPH_0:     r.digit = 4'd0;
      GLYPH_1:     r.digit = 4'd1;
      GLYPH_2:     r.digit = 4'd2;
      GLYPH_3:     r.digit = 4'd3;
      GLYPH_4:     r.digit = 4'd4;
      GLYPH_5:     r.digit = 4'd5;
      GLYPH_6:     r.digit = 4'd6;
      GLYPH_7:     r.digit = 4'd7;
      GLYPH_8:     r.digit = 4'd8;
      GLYPH_9:     r.digit = 4'd9;
      GLYPH_BLANK: r.blank = 1'b1;
      default: begin
        r.err   = 1'b1;
        r.digit = 4'hF;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/seg7_sync2.sv
// Two-flop synchronizer for a bus that is asynchronous to clk.
module seg7_sync2 #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/seg7_glyph_decoder.sv
// Receive side of the 7-segment glyph link: synchronize, wait for a stable
// pattern, decode it once, and hand it out through a one-entry valid/ready register.
module seg7_glyph_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg_in,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [3:0] out_digit,
  output logic       out_blank,
  output logic       out_err,
  output logic       overrun
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [6:0]       s;
  state_e           state_q, state_d;
  logic [6:0]       last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_valid_q, out_valid_d;
  logic [3:0]       out_digit_q, out_digit_d;
  logic             out_blank_q, out_blank_d;
  logic             out_err_q, out_err_d;
  logic             overrun_q, overrun_d;
  logic             emit, pop, load;
  seg7_dec_t        dec;

  seg7_sync2 #(.W(7)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (seg_in),
    .q   (s)
  );

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_digit_d = out_digit_q;
    out_blank_d = out_blank_q;
    out_err_d   = out_err_q;
    overrun_d   = overrun_q;
    emit        = 1'b0;
    dec         = seg7_decode(s);

    // Any change restarts the stability count; IDLE never re-emits an unchanged bus.
    case (state_q)
      IDLE: begin
        if (s != last_q) begin
          last_d  = s;
          cnt_d   = CNT_ONE;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        if (s != last_q) begin
          last_d = s;
          cnt_d  = CNT_ONE;
        end else if (cnt_q >= CNT_LAST) begin
          emit    = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A pop in the same cycle frees the slot, so emit+pop streams without a bubble.
    pop  = out_valid_q && out_ready;
    load = emit && (!out_valid_q || pop);
    if (load) begin
      out_valid_d = 1'b1;
      out_digit_d = dec.digit;
      out_blank_d = dec.blank;
      out_err_d   = dec.err;
    end else if (pop) begin
      out_valid_d = 1'b0;
    end
    if (emit && !load) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_digit_q <= 4'd0;
      out_blank_q <= 1'b0;
      out_err_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_digit_q <= out_digit_d;
      out_blank_q <= out_blank_d;
      out_err_q   <= out_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_digit = out_digit_q;
  assign out_blank = out_blank_q;
  assign out_err   = out_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_seg7_glyph_decoder.sv
// Self-checking bench for seg7_glyph_decoder: directed sequences, a glyph
// vector table and a randomized run against a run-length reference model.
module tb_seg7_glyph_decoder;

  localparam int SC = 4;
  // A pattern must be seen on this many consecutive synced samples (the first
  // sample opens SETTLE, so at least two are always needed).
  localparam int RUN_NEEDED = (SC < 2) ? 2 : SC;

  logic       clk;
  logic       rst;
  logic [6:0] seg;
  logic       ready;
  logic       out_valid;
  logic [3:0] out_digit;
  logic       out_blank;
  logic       out_err;
  logic       overrun;

  seg7_glyph_decoder #(.STABLE_CYCLES(SC), .CNT_W(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .seg_in    (seg),
    .out_ready (ready),
    .out_valid (out_valid),
    .out_digit (out_digit),
    .out_blank (out_blank),
    .out_err   (out_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [6:0] seg;
    logic [3:0] digit;
    logic       blank;
    logic       err;
  } vec_t;
  vec_t vecs[12];

  logic [6:0] glyphs[10];

  // reference model state
  logic [6:0] m_d1, m_d2, m_prev;
  int         m_run;
  logic       m_valid, m_blank, m_err, m_ovr;
  logic [3:0] m_digit;

  logic [5:0] pops[$];  // {err, blank, digit} of every handshake observed

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic ref_decode(input logic [6:0] p, output logic [3:0] d,
                            output logic b, output logic e);
    d = 4'hF; b = 1'b0; e = 1'b1;
    if (p == 7'h00) begin
      d = 4'd0; b = 1'b1; e = 1'b0;
    end
    for (int i = 0; i < 10; i++) begin
      if (glyphs[i] == p) begin
        d = 4'(i); e = 1'b0;
      end
    end
  endtask

  task automatic model_reset();
    m_d1 = '0; m_d2 = '0; m_prev = '0; m_run = 1000;
    m_valid = 1'b0; m_digit = 4'd0; m_blank = 1'b0; m_err = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic model_edge();
    logic [6:0] s;
    logic       emit, pop;
    if (rst) begin
      model_reset();
      return;
    end
    s = m_d2;
    m_d2 = m_d1;
    m_d1 = seg;
    if (s != m_prev) m_run = 1;
    else if (m_run < 1000) m_run++;
    m_prev = s;
    emit = (m_run == RUN_NEEDED);
    pop  = m_valid && ready;
    if (emit && (!m_valid || pop)) begin
      ref_decode(s, m_digit, m_blank, m_err);
      m_valid = 1'b1;
    end else begin
      if (emit) m_ovr = 1'b1;
      if (pop) m_valid = 1'b0;
    end
  endtask

  function automatic int dut_pack();
    return int'({out_valid, out_digit, out_blank, out_err, overrun});
  endfunction

  function automatic int model_pack();
    return int'({m_valid, m_digit, m_blank, m_err, m_ovr});
  endfunction

  task automatic tick();
    if (out_valid && ready) pops.push_back({out_err, out_blank, out_digit});
    @(posedge clk);
    model_edge();
    #1;
    check("cycle", dut_pack(), model_pack());
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int hold;
    glyphs = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
    vecs[0] = '{seg: 7'h01, digit: 4'hF, blank: 1'b0, err: 1'b1};
    vecs[1] = '{seg: 7'h00, digit: 4'h0, blank: 1'b1, err: 1'b0};
    for (int i = 0; i < 10; i++)
      vecs[i+2] = '{seg: glyphs[i], digit: 4'(i), blank: 1'b0, err: 1'b0};

    rst = 1'b0; seg = 7'h00; ready = 1'b0;
    model_reset();
    #1 rst = 1'b1;
    #1 check("reset_state", dut_pack(), 0);
    tick();
    tick();
    rst = 1'b0;

    // first symbol latency and single pulse
    seg = 7'h5B; ready = 1'b1;
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (out_valid) begin
        n = i;
        break;
      end
    end
    check("latency_5B", n, 6);
    check("digit_5B", int'({out_digit, out_blank, out_err}), int'({4'd2, 1'b0, 1'b0}));
    tick();
    check("one_pulse", int'(out_valid), 0);

    // short glitch must not be emitted
    pops.delete();
    seg = 7'h06;
    tick(); tick();
    seg = 7'h4F;
    repeat (20) tick();
    check("glitch_count", pops.size(), 1);
    if (pops.size() > 0) check("glitch_digit", int'(pops[0]), int'({2'b00, 4'd3}));

    // overrun while consumer stalls
    ready = 1'b0; seg = 7'h66;
    repeat (10) tick();
    seg = 7'h7F;
    repeat (10) tick();
    check("hold_digit", int'({out_valid, out_digit}), int'({1'b1, 4'd4}));
    check("overrun_set", int'(overrun), 1);
    pops.delete();
    ready = 1'b1;
    repeat (10) tick();
    check("stall_pops", pops.size(), 1);
    if (pops.size() > 0) check("stall_pop_digit", int'(pops[0][3:0]), 4);
    check("overrun_sticky", int'(overrun), 1);

    // table of illegal, blank and all ten glyphs
    seg = 7'h00;
    do_reset();
    ready = 1'b1;
    for (int v = 0; v < 12; v++) begin
      pops.delete();
      seg = vecs[v].seg;
      repeat (14) tick();
      check($sformatf("vec%0d_count", v), pops.size(), 1);
      if (pops.size() > 0)
        check($sformatf("vec%0d_fields", v), int'(pops[0]),
              int'({vecs[v].err, vecs[v].blank, vecs[v].digit}));
    end
    check("sweep_no_overrun", int'(overrun), 0);

    // asynchronous reset while holding an output and settling a new one
    ready = 1'b0; seg = 7'h66;
    repeat (10) tick();
    seg = 7'h06;
    repeat (4) tick();
    #3 rst = 1'b1;
    #1 model_reset();
    check("rst_mid_settle", dut_pack(), 0);
    seg = 7'h6F;
    tick(); tick();
    rst = 1'b0; ready = 1'b1;
    pops.delete();
    repeat (15) tick();
    check("post_rst_count", pops.size(), 1);
    if (pops.size() > 0) check("post_rst_digit", int'(pops[0]), int'({2'b00, 4'd9}));

    // randomized traffic against the model
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        n = int'($urandom_range(0, 9));
        if (n < 7) seg = glyphs[$urandom_range(0, 9)];
        else if (n == 7) seg = 7'h00;
        else seg = 7'($urandom);
        hold = int'($urandom_range(1, 8));
      end
      hold--;
      ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 499) == 0) rst = 1'b1;
      else rst = 1'b0;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
